arth_sequencer: RTL and testbench
=================================

// Module: arth_sequencer
// PURPOSE
//  Command-level controller for the sign-magnitude arithmetic datapath (add/mul/sub unit).
//  - Accepts one operation request at a time over a valid/ready handshake.
//  - Drives the unit's operand, opcode and newop inputs and waits for the opcode pipeline to settle.
//  - Captures answer/overflow and returns them over a valid/ready response handshake.
//  - Keeps an accumulator so chained calculator-style operations reuse the previous result.
// PARAMETERS
//  W      17  operand/result width, sign-magnitude (MSB = sign)
//  SETTLE 2   cycles from the newop pulse until the unit's answer is valid
//  CNT_W  16  width of completed-operation counter
// PORTS
//  clock        in  1      system clock, all logic rising-edge
//  reset_n      in  1      asynchronous active-low reset
//  req_valid    in  1      request present
//  req_ready    out 1      sequencer can accept request (IDLE only)
//  req_opcode   in  2      00 add V1+V2, 01 mul, 10 sub V2-V1, 11 illegal (forwarded)
//  req_v1       in  W      operand 1
//  req_v2       in  W      operand 2
//  req_chain    in  1      1: substitute accumulator for V2
//  clr_acc      in  1      synchronous clear of accumulator and err_sticky
//  rsp_valid    out 1      result held for consumer
//  rsp_ready    in  1      consumer accepts result
//  rsp_answer   out W      captured answer, sign-magnitude
//  rsp_ovw      out 1      captured overflow/illegal flag
//  arth_reset   out 1      active-high sync reset to the arithmetic unit
//  arth_v1      out W      operand 1 to unit
//  arth_v2      out W      operand 2 to unit
//  arth_opcode  out 2      opcode to unit
//  arth_newop   out 1      one-cycle load strobe to unit
//  arth_answer  in  W      unit result
//  arth_ovw     in  1      unit overflow
//  err_sticky   out 1      set on any captured ovw; cleared by clr_acc
//  op_count     out CNT_W  completed operations; wraps at 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset values:
//  - All outputs 0 except arth_reset=1; state IDLE; accumulator 0.
//  - arth_reset stays 1 for the first clock edge after reset_n rises, then 0.
//  - req_ready stays 0 while arth_reset=1.
//  FSM: IDLE -> ISSUE -> WAIT -> CAPTURE -> RESP -> IDLE.
//  - IDLE: req_ready=1. On req_valid, register the operands and opcode.
//    - If req_chain=1, arth_v2 takes the accumulator value.
//    - Go to ISSUE.
//  - ISSUE: arth_newop=1 for exactly this cycle. Load the wait counter with SETTLE-1. Go to WAIT.
//  - WAIT: decrement the counter each cycle; go to CAPTURE when it reaches 0.
//  - CAPTURE: register arth_answer -> rsp_answer and arth_ovw -> rsp_ovw.
//    - If ovw=0, accumulator <= answer; if ovw=1, accumulator is unchanged.
//    - err_sticky |= ovw; op_count increments.
//    - Go to RESP.
//  - RESP: rsp_valid=1, rsp_answer and rsp_ovw held stable. On rsp_ready, go to IDLE.
//  Latency and operand hold:
//  - Request accept to rsp_valid is SETTLE+2 cycles (4 with default).
//  - arth_v1, arth_v2 and arth_opcode are held stable from ISSUE through CAPTURE.
//  - The next request is accepted one cycle after the response handshake at the earliest.
//  Boundary conditions:
//  - Simultaneous clr_acc and CAPTURE: clear wins for accumulator and err_sticky; op_count still increments.
//  - clr_acc in any state does not disturb an in-flight operation's operands.
//  - Chain with cleared accumulator uses +0 (17'h00000).
//  - Opcode 11 is forwarded unchanged; the unit reports ovw=1, which is captured normally.
//  - reset_n low mid-operation aborts immediately: rsp_valid=0, the result is lost, arth_reset reasserts.
//  - Negative zero (17'h10000) from the unit passes through unmodified.
// STRUCTURE
//  - Shared package arth_pkg: state enum typedef, opcode localparams (OP_ADD, OP_MUL, OP_SUB), W default.
//  - Single module. No sub-module; the datapath unit is instantiated by the parent, not here.
// TESTING
//  1. Add: v1=17'h00005, v2=17'h00003, op 00 -> answer 17'h00008, ovw 0, rsp_valid 4 cycles after accept.
//  2. Sub: v1=17'h00005, v2=17'h00003, op 10 -> answer 17'h10002 (-2), ovw 0.
//  3. Mul overflow: v1=17'h00100, v2=17'h00100, op 01 -> ovw 1, err_sticky 1, accumulator unchanged.
//  4. Chain: add 2+3=5, then chain v1=17'h00004 op 00 -> 9. Hold rsp_ready low 5 cycles -> answer stable, req_ready 0.
//  5. Illegal op 11 -> answer 0, ovw 1. Then clr_acc with a chained add of 1 -> answer 17'h00001, err_sticky 0.
//  6. reset_n low during WAIT -> no rsp_valid; arth_reset high 1 cycle after release; next add completes correctly.

Source files
------------

// File: rtl/arth_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arth_pkg
// Brief   : Shared types and constants for the arithmetic-unit sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package arth_pkg;

    localparam int ARTH_W = 17;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/arth_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : arth_sequencer_if
// Brief   : Request/response handshake bundle between a client and the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface arth_sequencer_if
    import arth_pkg::*;
#(
    parameter int W = ARTH_W
);
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_opcode;
    logic [W-1:0] req_v1;
    logic [W-1:0] req_v2;
    logic         req_chain;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_answer;
    logic         rsp_ovw;

    modport master (
        output req_valid, req_opcode, req_v1, req_v2, req_chain, rsp_ready,
        input  req_ready, rsp_valid, rsp_answer, rsp_ovw
    );

    modport slave (
        input  req_valid, req_opcode, req_v1, req_v2, req_chain, rsp_ready,
        output req_ready, rsp_valid, rsp_answer, rsp_ovw
    );
endinterface
`default_nettype wire

// File: rtl/arth_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : arth_sequencer
// Brief   : Command-level controller for the sign-magnitude add/mul/sub unit.
// Revision: 1.0 - initial release
// ============================================================================
module arth_sequencer
    import arth_pkg::*;
#(
    parameter int W      = ARTH_W,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    arth_sequencer_if.slave  bus,
    input  logic             clr_acc,
    output logic             arth_reset,
    output logic [W-1:0]     arth_v1,
    output logic [W-1:0]     arth_v2,
    output logic [1:0]       arth_opcode,
    output logic             arth_newop,
    input  logic [W-1:0]     arth_answer,
    input  logic             arth_ovw,
    output logic             err_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t         r_state;
    state_t         w_state_next;
    logic           w_accept;
    logic           w_newop;
    logic           w_req_ready;
    logic           w_rsp_valid;
    logic           w_capture;

    logic           r_arth_reset;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_v1;
    logic [W-1:0]   r_v2;
    logic [1:0]     r_opcode;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_answer;
    logic           r_ovw;
    logic           r_err;
    logic [CNT_W-1:0] r_op_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_newop      = 1'b0;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Hold off requests until the unit has seen its reset edge.
                w_req_ready = !r_arth_reset;
                if (w_req_ready && bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_newop      = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_capture    = 1'b1;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_arth_reset <= 1'b1;
            r_cnt        <= '0;
            r_v1         <= '0;
            r_v2         <= '0;
            r_opcode     <= '0;
            r_acc        <= '0;
            r_answer     <= '0;
            r_ovw        <= 1'b0;
            r_err        <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_arth_reset <= 1'b0;
            if (w_accept) begin
                r_v1     <= bus.req_v1;
                r_v2     <= bus.req_chain ? r_acc : bus.req_v2;
                r_opcode <= bus.req_opcode;
            end
            if (w_newop) begin
                r_cnt <= CW'(SETTLE - 1);
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_answer   <= arth_answer;
                r_ovw      <= arth_ovw;
                r_op_count <= r_op_count + CNT_W'(1);
                if (!arth_ovw) begin
                    r_acc <= arth_answer;
                end
                if (arth_ovw) begin
                    r_err <= 1'b1;
                end
            end
            // Clear takes priority over a same-cycle capture.
            if (clr_acc) begin
                r_acc <= '0;
                r_err <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_answer = r_answer;
    assign bus.rsp_ovw    = r_ovw;

    assign arth_reset  = r_arth_reset;
    assign arth_v1     = r_v1;
    assign arth_v2     = r_v2;
    assign arth_opcode = r_opcode;
    assign arth_newop  = w_newop;
    assign err_sticky  = r_err;
    assign op_count    = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_arth_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_arth_sequencer
// Brief   : Directed bench for arth_sequencer with a behavioural sign-magnitude unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_arth_sequencer;
    import arth_pkg::*;

    localparam int W = 17;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         clr_acc;
    logic         arth_reset;
    logic [W-1:0] arth_v1;
    logic [W-1:0] arth_v2;
    logic [1:0]   arth_opcode;
    logic         arth_newop;
    logic [W-1:0] arth_answer;
    logic         arth_ovw;
    logic         err_sticky;
    logic [15:0]  op_count;

    logic [17:0]  unit_q;
    logic         force_nz;
    int           newop_cnt = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clock = ~clock;

    arth_sequencer_if #(.W(W)) bus ();

    arth_sequencer #(.W(W), .SETTLE(2), .CNT_W(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .clr_acc     (clr_acc),
        .arth_reset  (arth_reset),
        .arth_v1     (arth_v1),
        .arth_v2     (arth_v2),
        .arth_opcode (arth_opcode),
        .arth_newop  (arth_newop),
        .arth_answer (arth_answer),
        .arth_ovw    (arth_ovw),
        .err_sticky  (err_sticky),
        .op_count    (op_count)
    );

    function automatic logic [17:0] sm_add(input logic [16:0] a, input logic [16:0] b);
        logic [16:0] s;
        logic [15:0] ma;
        logic [15:0] mb;
        ma = a[15:0];
        mb = b[15:0];
        if (a[16] == b[16]) begin
            s = {1'b0, ma} + {1'b0, mb};
            if (s[16]) return 18'h20000;
            return {1'b0, a[16], s[15:0]};
        end
        if (ma >= mb) begin
            s = {1'b0, ma - mb};
            return {1'b0, (s == 17'd0) ? 1'b0 : a[16], s[15:0]};
        end
        s = {1'b0, mb - ma};
        return {1'b0, b[16], s[15:0]};
    endfunction

    function automatic logic [17:0] unit_f(input logic [16:0] a, input logic [16:0] b,
                                           input logic [1:0] op);
        logic [31:0] p;
        case (op)
            OP_ADD: return sm_add(a, b);
            OP_SUB: return sm_add(b, {~a[16], a[15:0]});
            OP_MUL: begin
                p = a[15:0] * b[15:0];
                if (p[31:16] != 16'd0) return 18'h20000;
                return {1'b0, (p == 32'd0) ? 1'b0 : (a[16] ^ b[16]), p[15:0]};
            end
            default: return 18'h20000;
        endcase
    endfunction

    // Stand-in for the arithmetic unit: result registered one cycle after its operands.
    always @(posedge clock) begin
        if (arth_reset)    unit_q <= 18'h0;
        else if (force_nz) unit_q <= {1'b0, 17'h10000};
        else               unit_q <= unit_f(arth_v1, arth_v2, arth_opcode);
    end
    assign arth_answer = unit_q[16:0];
    assign arth_ovw    = unit_q[17];

    always @(negedge clock) begin
        if (arth_newop === 1'b1) newop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [16:0] v1,
                         input logic [16:0] v2, input logic chain);
        int guard;
        int lat;
        int nstart;
        bus.req_opcode = op;
        bus.req_v1     = v1;
        bus.req_v2     = v2;
        bus.req_chain  = chain;
        bus.req_valid  = 1'b1;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        nstart = newop_cnt;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.req_chain = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " newop pulses"}, newop_cnt - nstart, 1);
        check({tag, " v1 held"}, arth_v1, v1);
    endtask

    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus.rsp_ready = 1'b0;
        check({tag, " rsp_valid drop"}, bus.rsp_valid, 0);
        check({tag, " req_ready back"}, bus.req_ready, 1);
    endtask

    initial begin
        reset_n        = 1'b0;
        clr_acc        = 1'b0;
        force_nz       = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_opcode = 2'b00;
        bus.req_v1     = '0;
        bus.req_v2     = '0;
        bus.req_chain  = 1'b0;
        bus.rsp_ready  = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("rst req_ready", bus.req_ready, 0);
        check("rst rsp_valid", bus.rsp_valid, 0);
        check("rst arth_reset", arth_reset, 1);
        check("rst newop", arth_newop, 0);
        check("rst err", err_sticky, 0);
        check("rst count", op_count, 0);
        check("rst arth_v1", arth_v1, 0);
        reset_n = 1'b1;
        #1;
        check("rel arth_reset held", arth_reset, 1);
        check("rel req_ready low", bus.req_ready, 0);
        @(posedge clock); #1;
        check("rel arth_reset drop", arth_reset, 0);
        check("rel req_ready", bus.req_ready, 1);

        // Add 5+3
        issue("add", OP_ADD, 17'h00005, 17'h00003, 1'b0);
        check("add answer", bus.rsp_answer, 17'h00008);
        check("add ovw", bus.rsp_ovw, 0);
        check("add count", op_count, 1);
        finish_rsp("add");

        // Sub: 3-5 = -2
        issue("sub", OP_SUB, 17'h00005, 17'h00003, 1'b0);
        check("sub answer", bus.rsp_answer, 17'h10002);
        check("sub ovw", bus.rsp_ovw, 0);
        finish_rsp("sub");

        // Mul overflow keeps accumulator at -2
        issue("mul", OP_MUL, 17'h00100, 17'h00100, 1'b0);
        check("mul ovw", bus.rsp_ovw, 1);
        check("mul err", err_sticky, 1);
        check("mul count", op_count, 3);
        finish_rsp("mul");
        issue("accchk", OP_ADD, 17'h00000, 17'h00077, 1'b1);
        check("accchk answer", bus.rsp_answer, 17'h10002);
        finish_rsp("accchk");

        // Chain 2+3 then +4, response held off
        issue("ch1", OP_ADD, 17'h00002, 17'h00003, 1'b0);
        check("ch1 answer", bus.rsp_answer, 17'h00005);
        finish_rsp("ch1");
        issue("ch2", OP_ADD, 17'h00004, 17'h00033, 1'b1);
        check("ch2 v2 from acc", arth_v2, 17'h00005);
        for (int i = 0; i < 5; i++) begin
            check("hold answer", bus.rsp_answer, 17'h00009);
            check("hold req_ready", bus.req_ready, 0);
            check("hold rsp_valid", bus.rsp_valid, 1);
            @(posedge clock); #1;
        end
        finish_rsp("ch2");
        check("ch2 count", op_count, 6);

        // Illegal opcode forwarded
        issue("ill", OP_ILL, 17'h00007, 17'h00009, 1'b0);
        check("ill opcode fwd", arth_opcode, 2'b11);
        check("ill answer", bus.rsp_answer, 17'h00000);
        check("ill ovw", bus.rsp_ovw, 1);
        check("ill err", err_sticky, 1);
        finish_rsp("ill");

        // clr_acc held through a whole operation: operands intact, clear wins
        clr_acc = 1'b1;
        issue("clrop", OP_ADD, 17'h00010, 17'h00020, 1'b0);
        check("clrop answer", bus.rsp_answer, 17'h00030);
        check("clrop err", err_sticky, 0);
        check("clrop count", op_count, 8);
        clr_acc = 1'b0;
        finish_rsp("clrop");
        issue("clrch", OP_ADD, 17'h00001, 17'h00055, 1'b1);
        check("clrch v2 zero", arth_v2, 17'h00000);
        check("clrch answer", bus.rsp_answer, 17'h00001);
        check("clrch err", err_sticky, 0);
        finish_rsp("clrch");

        // Negative zero passes through
        force_nz = 1'b1;
        issue("nz", OP_ADD, 17'h00001, 17'h00001, 1'b0);
        check("nz answer", bus.rsp_answer, 17'h10000);
        check("nz ovw", bus.rsp_ovw, 0);
        finish_rsp("nz");
        force_nz = 1'b0;
        check("nz count", op_count, 10);

        // Reset during WAIT aborts the operation
        bus.req_opcode = OP_ADD;
        bus.req_v1     = 17'h00006;
        bus.req_v2     = 17'h00007;
        bus.req_valid  = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("abort rsp_valid", bus.rsp_valid, 0);
        check("abort arth_reset", arth_reset, 1);
        check("abort newop", arth_newop, 0);
        check("abort count", op_count, 0);
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        #1;
        check("abort rel arth_reset", arth_reset, 1);
        check("abort rel req_ready", bus.req_ready, 0);
        @(posedge clock); #1;
        check("abort arth_reset drop", arth_reset, 0);
        check("abort req_ready", bus.req_ready, 1);
        check("abort no rsp", bus.rsp_valid, 0);
        issue("post", OP_ADD, 17'h00006, 17'h00007, 1'b0);
        check("post answer", bus.rsp_answer, 17'h0000D);
        check("post count", op_count, 1);
        finish_rsp("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
